keypad_lock_ctrl: RTL and testbench
===================================

Name: keypad_lock_ctrl

Overview:
Parametrised keypad combination-lock controller.
- Takes the raw one-hot keypad vector and decodes press events.
- Shifts entered digits into a display register and compares the code on ENTER.
- Enforces a retry limit with a timed lockout countdown.
- Drives a three-mode buzzer (key click, success, fail).
- Supports runtime password change while unlocked. Sits between the keypad scanner and the 7-segment display driver.

Parameters:
- DIGITS, 3: code length in nibbles (1..6).
- CLK_HZ, 50_000_000: clk frequency; derives the 1 Hz tick and buzzer timing.
- MAX_TRIES, 3: consecutive failures that trigger lockout (1..15).
- LOCK_SEC, 20: lockout duration in seconds (1..99).
- INIT_CODE, 12'h246: password after reset; width 4*DIGITS.

Ports:
- clk  in  1  system clock
- RSTn  in  1  asynchronous active-low reset
- onehot  in  16  raw keypad one-hot vector; 0 = no key
- disp  out  4*DIGITS  display nibbles, LSB nibble = newest digit; 4'hF = blank
- disp_cnt  out  3  number of digits entered (0..DIGITS)
- unlocked  out  1  high in UNLOCKED and SET_NEW
- locked_out  out  1  high in LOCKOUT
- lock_remain  out  8  BCD seconds left in lockout; 8'h00 otherwise
- tries  out  4  consecutive failed attempts
- buzzer  out  1  square-wave buzzer drive

Behaviour:
- Reset (async, RSTn=0): state=ENTRY, disp=all 4'hF, disp_cnt=0, tries=0, unlocked=0, locked_out=0, lock_remain=0, buzzer=0, stored code=INIT_CODE, all counters 0.
- Key decode:
  - onehot is registered once.
  - An event fires when the registered value is non-zero and differs from the previous registered value. This gives a 1-cycle pulse per new press; a held key fires once.
  - Non-one-hot patterns are ignored.
  - Decode-to-action latency is 2 clk.
- Key map (package):
  - 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9.
  - 0x0001=ENTER, 0x1000=CLEAR, 0x0100=RESET_ALL, 0x0002=SET, 0x0004=BACK.
- ENTRY state:
  - Digit with disp_cnt<DIGITS: disp <= {disp[4*DIGITS-5:0], digit}, disp_cnt+1, click tone.
  - Digit with disp_cnt==DIGITS: ignored, no tone.
  - BACK: disp <= {4'hF, disp[4*DIGITS-1:4]}, disp_cnt-1; ignored at 0.
  - CLEAR: blank the display, disp_cnt=0.
  - ENTER with disp_cnt<DIGITS: ignored.
  - ENTER with disp_cnt==DIGITS and match: state UNLOCKED, tries=0, success tone.
  - ENTER with disp_cnt==DIGITS and mismatch: tries+1, blank the display, fail tone. If the new tries==MAX_TRIES, go to LOCKOUT with lock_remain=BCD(LOCK_SEC) and tries=0.
- UNLOCKED state:
  - disp holds the code last entered.
  - CLEAR: relock to ENTRY, blank the display.
  - SET: go to SET_NEW, blank the display, disp_cnt=0.
- SET_NEW state:
  - Digit and BACK entry as in ENTRY.
  - ENTER with DIGITS digits: stored code <= disp, success tone, go to UNLOCKED.
  - CLEAR: abort to UNLOCKED; code unchanged.
- LOCKOUT state:
  - All keys ignored except RESET_ALL.
  - 1 Hz tick (counter wraps at CLK_HZ-1, runs only in LOCKOUT, cleared on entry).
  - Each tick decrements lock_remain in BCD: units 0 goes to 9 with a tens borrow.
  - On the tick where lock_remain==01: lock_remain=00, go to ENTRY.
- RESET_ALL in any state: go to ENTRY, blank the display, disp_cnt=0, tries=0. Stored code is kept. This is the only key accepted in LOCKOUT.
- Buzzer:
  - A new tone request pre-empts the current one. Request priority in the same cycle: fail > success > click.
  - Click: half-period CLK_HZ/1000, duration CLK_HZ/5.
  - Success: half-period CLK_HZ/2000, duration 3*CLK_HZ/5.
  - Fail: half-period CLK_HZ/500, duration 3*CLK_HZ/10. Forced low while the elapsed count is in (CLK_HZ/10, CLK_HZ/5).
  - Output starts high on request. buzzer=0 when idle and at the end of every tone.
- All duration and tick counters are 32 bits; widths derive from CLK_HZ.

Decomposition:
- Package keypad_lock_pkg holds:
  - state enum {ENTRY, UNLOCKED, SET_NEW, LOCKOUT};
  - key-code enum and the one-hot-to-key mapping constants;
  - tone enum {NONE, CLICK, SUCCESS, FAIL}.
- Sub-module buzzer_tone_gen: inputs tone request and type, output buzzer, parameter CLK_HZ.
- Key decode and the FSM stay in the top level.

Test Plan (CLK_HZ=1000, DIGITS=3, MAX_TRIES=3, LOCK_SEC=3):
- Press 2,4,6 then ENTER, each held 5 cycles -> disp=12'h246, disp_cnt=3, unlocked=1, tries=0; buzzer toggles every 0.5 cycles rounded to 1, for 600 cycles.
- Enter 1,1,1 + ENTER three times -> tries goes 1, 2; third attempt gives locked_out=1, lock_remain=8'h03, then 02, 01 at 1000-cycle ticks, then 00 and ENTRY; digit presses during lockout are ignored.
- Hold key 5 for 50 cycles -> exactly one digit shifted in, one click; press 1,2,3,4 -> disp=12'h123 (4th ignored, no tone); BACK -> disp=12'hF12, disp_cnt=2.
- Unlock with 246, SET, 9,0,1, ENTER, CLEAR, then enter 246 -> fail; enter 901 -> unlocked=1.
- Deassert RSTn mid-lockout and mid-tone -> all outputs reset immediately (async); stored code returns to 12'h246.
- RESET_ALL during LOCKOUT -> locked_out=0, lock_remain=0, tries=0 on the action cycle.

Source files
------------

// File: rtl/keypad_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_lock_pkg
//  Purpose  : Shared types and constants for the keypad combination lock:
//             FSM states, decoded key codes, one-hot key map, tone types and
//             small BCD helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    SET_NEW  = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  // Digits keep their numeric value so the code can be shifted straight
  // into the display register.
  typedef enum logic [3:0] {
    KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3, KEY_4 = 4'd4,
    KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7, KEY_8 = 4'd8, KEY_9 = 4'd9,
    KEY_ENTER     = 4'd10,
    KEY_CLEAR     = 4'd11,
    KEY_RESET_ALL = 4'd12,
    KEY_SET       = 4'd13,
    KEY_BACK      = 4'd14,
    KEY_NONE      = 4'd15
  } key_t;

  typedef enum logic [1:0] {
    TONE_NONE    = 2'd0,
    TONE_CLICK   = 2'd1,
    TONE_SUCCESS = 2'd2,
    TONE_FAIL    = 2'd3
  } tone_t;

  // Raw keypad one-hot positions
  localparam logic [15:0] OH_0         = 16'h0008;
  localparam logic [15:0] OH_1         = 16'h0080;
  localparam logic [15:0] OH_2         = 16'h0040;
  localparam logic [15:0] OH_3         = 16'h0020;
  localparam logic [15:0] OH_4         = 16'h0800;
  localparam logic [15:0] OH_5         = 16'h0400;
  localparam logic [15:0] OH_6         = 16'h0200;
  localparam logic [15:0] OH_7         = 16'h8000;
  localparam logic [15:0] OH_8         = 16'h4000;
  localparam logic [15:0] OH_9         = 16'h2000;
  localparam logic [15:0] OH_ENTER     = 16'h0001;
  localparam logic [15:0] OH_CLEAR     = 16'h1000;
  localparam logic [15:0] OH_RESET_ALL = 16'h0100;
  localparam logic [15:0] OH_SET       = 16'h0002;
  localparam logic [15:0] OH_BACK      = 16'h0004;

  // Anything that is not exactly one mapped bit decodes to KEY_NONE.
  function automatic key_t decode_key(input logic [15:0] oh);
    key_t k;
    case (oh)
      OH_0:         k = KEY_0;
      OH_1:         k = KEY_1;
      OH_2:         k = KEY_2;
      OH_3:         k = KEY_3;
      OH_4:         k = KEY_4;
      OH_5:         k = KEY_5;
      OH_6:         k = KEY_6;
      OH_7:         k = KEY_7;
      OH_8:         k = KEY_8;
      OH_9:         k = KEY_9;
      OH_ENTER:     k = KEY_ENTER;
      OH_CLEAR:     k = KEY_CLEAR;
      OH_RESET_ALL: k = KEY_RESET_ALL;
      OH_SET:       k = KEY_SET;
      OH_BACK:      k = KEY_BACK;
      default:      k = KEY_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Two-digit BCD decrement; units 0 borrows from tens.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_lock_ctrl_buzzer.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_tone_gen
//  Purpose  : Three-mode square-wave buzzer (click / success / fail). A new
//             request restarts the tone; output is low when idle.
//  Revision : 1.0 - initial release
// ============================================================================
module buzzer_tone_gen
  import keypad_lock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req,
  input  tone_t tone_type,
  output logic  buzzer
);

  // Very low clock rates would round some periods to zero; clamp to 1.
  function automatic logic [31:0] atleast1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  localparam logic [31:0] HZ         = 32'(CLK_HZ);
  localparam logic [31:0] CLICK_HALF = atleast1(HZ / 1000);
  localparam logic [31:0] CLICK_DUR  = atleast1(HZ / 5);
  localparam logic [31:0] SUCC_HALF  = atleast1(HZ / 2000);
  localparam logic [31:0] SUCC_DUR   = atleast1((3 * HZ) / 5);
  localparam logic [31:0] FAIL_HALF  = atleast1(HZ / 500);
  localparam logic [31:0] FAIL_DUR   = atleast1((3 * HZ) / 10);
  localparam logic [31:0] MUTE_LO    = HZ / 10;
  localparam logic [31:0] MUTE_HI    = HZ / 5;

  tone_t       cur;
  logic [31:0] elapsed;
  logic [31:0] half_cnt;
  logic        phase;
  logic [31:0] half_len;
  logic [31:0] dur_len;
  logic        mute;

  // Period and duration of the tone currently playing
  always_comb begin
    half_len = CLICK_HALF;
    dur_len  = CLICK_DUR;
    case (cur)
      TONE_SUCCESS: begin half_len = SUCC_HALF; dur_len = SUCC_DUR; end
      TONE_FAIL:    begin half_len = FAIL_HALF; dur_len = FAIL_DUR; end
      default:      begin half_len = CLICK_HALF; dur_len = CLICK_DUR; end
    endcase
  end

  // Fail tone has a silent gap in its middle, giving a double beep
  assign mute   = (cur == TONE_FAIL) && (elapsed > MUTE_LO) && (elapsed < MUTE_HI);
  assign buzzer = phase && (cur != TONE_NONE) && !mute;

  // Tone sequencer: restart on request, toggle each half period, stop at end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= TONE_NONE;
      elapsed  <= 32'd0;
      half_cnt <= 32'd0;
      phase    <= 1'b0;
    end else if (req && (tone_type != TONE_NONE)) begin
      cur      <= tone_type;
      elapsed  <= 32'd0;
      half_cnt <= 32'd0;
      phase    <= 1'b1;
    end else if (cur != TONE_NONE) begin
      if (elapsed == dur_len - 32'd1) begin
        cur      <= TONE_NONE;
        elapsed  <= 32'd0;
        half_cnt <= 32'd0;
        phase    <= 1'b0;
      end else begin
        elapsed <= elapsed + 32'd1;
        if (half_cnt == half_len - 32'd1) begin
          half_cnt <= 32'd0;
          phase    <= ~phase;
        end else begin
          half_cnt <= half_cnt + 32'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_lock_ctrl
//  Purpose  : Keypad combination-lock controller: key event decode, digit
//             entry, code compare, retry limit with BCD lockout countdown,
//             runtime password change and buzzer feedback.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int unsigned       DIGITS    = 3,
  parameter int unsigned       CLK_HZ    = 50_000_000,
  parameter int unsigned       MAX_TRIES = 3,
  parameter int unsigned       LOCK_SEC  = 20,
  parameter logic [4*DIGITS-1:0] INIT_CODE = 12'h246
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [15:0]           onehot,
  output logic [4*DIGITS-1:0]   disp,
  output logic [2:0]            disp_cnt,
  output logic                  unlocked,
  output logic                  locked_out,
  output logic [7:0]            lock_remain,
  output logic [3:0]            tries,
  output logic                  buzzer
);

  localparam int          W         = 4 * DIGITS;
  localparam logic [W-1:0] BLANK    = '1;
  localparam logic [2:0]  FULL      = 3'(DIGITS);
  localparam logic [3:0]  TRY_LIM   = 4'(MAX_TRIES);
  localparam logic [7:0]  LOCK_BCD  = to_bcd(LOCK_SEC);
  localparam logic [31:0] TICK_LAST = 32'(CLK_HZ - 1);

  // Newest digit enters at the low nibble
  function automatic logic [W-1:0] shl_digit(input logic [W-1:0] v, input logic [3:0] d);
    return (v << 4) | W'(d);
  endfunction

  // Drop the newest digit, refill the top nibble with blank
  function automatic logic [W-1:0] shr_digit(input logic [W-1:0] v);
    return (v >> 4) | (W'(4'hF) << (W - 4));
  endfunction

  logic [15:0]  key_q;
  logic [15:0]  key_prev;
  key_t         key_dec;
  logic         key_evt;
  key_t         key_code;

  state_t       state;
  logic [W-1:0] code;
  logic [31:0]  tick_cnt;
  logic         tone_req;
  tone_t        tone_sel;

  assign key_dec    = decode_key(key_q);
  assign unlocked   = (state == UNLOCKED) || (state == SET_NEW);
  assign locked_out = (state == LOCKOUT);

  // Register the keypad and emit one event per new valid press
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      key_q    <= 16'h0000;
      key_prev <= 16'h0000;
      key_evt  <= 1'b0;
      key_code <= KEY_NONE;
    end else begin
      key_q    <= onehot;
      key_prev <= key_q;
      if ((key_q != 16'h0000) && (key_q != key_prev) && (key_dec != KEY_NONE)) begin
        key_evt  <= 1'b1;
        key_code <= key_dec;
      end else begin
        key_evt  <= 1'b0;
        key_code <= KEY_NONE;
      end
    end
  end

  // Main lock FSM: entry, compare, unlock, password change, lockout timer
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ENTRY;
      disp        <= BLANK;
      disp_cnt    <= 3'd0;
      tries       <= 4'd0;
      lock_remain <= 8'h00;
      code        <= INIT_CODE;
      tick_cnt    <= 32'd0;
      tone_req    <= 1'b0;
      tone_sel    <= TONE_NONE;
    end else begin
      tone_req <= 1'b0;
      tone_sel <= TONE_NONE;

      if (state == LOCKOUT) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= 32'd0;
          if (lock_remain == 8'h01) begin
            lock_remain <= 8'h00;
            state       <= ENTRY;
          end else begin
            lock_remain <= bcd_dec(lock_remain);
          end
        end else begin
          tick_cnt <= tick_cnt + 32'd1;
        end
      end

      if (key_evt) begin
        if (key_code == KEY_RESET_ALL) begin
          state       <= ENTRY;
          disp        <= BLANK;
          disp_cnt    <= 3'd0;
          tries       <= 4'd0;
          lock_remain <= 8'h00;
          tick_cnt    <= 32'd0;
        end else begin
          case (state)
            ENTRY, SET_NEW: begin
              if (key_code <= KEY_9) begin
                if (disp_cnt < FULL) begin
                  disp     <= shl_digit(disp, 4'(key_code));
                  disp_cnt <= disp_cnt + 3'd1;
                  tone_req <= 1'b1;
                  tone_sel <= TONE_CLICK;
                end
              end else begin
                case (key_code)
                  KEY_BACK: begin
                    if (disp_cnt != 3'd0) begin
                      disp     <= shr_digit(disp);
                      disp_cnt <= disp_cnt - 3'd1;
                    end
                  end
                  KEY_CLEAR: begin
                    disp     <= BLANK;
                    disp_cnt <= 3'd0;
                    // In password change, CLEAR aborts back to unlocked
                    if (state == SET_NEW) state <= UNLOCKED;
                  end
                  KEY_ENTER: begin
                    if (disp_cnt == FULL) begin
                      if (state == SET_NEW) begin
                        code     <= disp;
                        state    <= UNLOCKED;
                        tone_req <= 1'b1;
                        tone_sel <= TONE_SUCCESS;
                      end else if (disp == code) begin
                        state    <= UNLOCKED;
                        tries    <= 4'd0;
                        tone_req <= 1'b1;
                        tone_sel <= TONE_SUCCESS;
                      end else begin
                        disp     <= BLANK;
                        disp_cnt <= 3'd0;
                        tone_req <= 1'b1;
                        tone_sel <= TONE_FAIL;
                        if (tries + 4'd1 == TRY_LIM) begin
                          state       <= LOCKOUT;
                          tries       <= 4'd0;
                          lock_remain <= LOCK_BCD;
                          tick_cnt    <= 32'd0;
                        end else begin
                          tries <= tries + 4'd1;
                        end
                      end
                    end
                  end
                  default: ;
                endcase
              end
            end
            UNLOCKED: begin
              if (key_code == KEY_CLEAR) begin
                state    <= ENTRY;
                disp     <= BLANK;
                disp_cnt <= 3'd0;
              end else if (key_code == KEY_SET) begin
                state    <= SET_NEW;
                disp     <= BLANK;
                disp_cnt <= 3'd0;
              end
            end
            default: ; // LOCKOUT ignores everything but RESET_ALL
          endcase
        end
      end
    end
  end

  buzzer_tone_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_buzzer (
    .clk       (clk),
    .rst_n     (RSTn),
    .req       (tone_req),
    .tone_type (tone_sel),
    .buzzer    (buzzer)
  );

endmodule
`default_nettype wire

// File: tb/tb_keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_lock_ctrl
//  Purpose  : Self-checking bench for keypad_lock_ctrl (CLK_HZ=1000,
//             DIGITS=3, MAX_TRIES=3, LOCK_SEC=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_lock_ctrl;

  localparam int HZ = 1000;

  logic        clk;
  logic        RSTn;
  logic [15:0] onehot;
  logic [11:0] disp;
  logic [2:0]  disp_cnt;
  logic        unlocked;
  logic        locked_out;
  logic [7:0]  lock_remain;
  logic [3:0]  tries;
  logic        buzzer;

  keypad_lock_ctrl #(
    .DIGITS    (3),
    .CLK_HZ    (HZ),
    .MAX_TRIES (3),
    .LOCK_SEC  (3),
    .INIT_CODE (12'h246)
  ) dut (
    .clk         (clk),
    .RSTn        (RSTn),
    .onehot      (onehot),
    .disp        (disp),
    .disp_cnt    (disp_cnt),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .lock_remain (lock_remain),
    .tries       (tries),
    .buzzer      (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key index: 0..9 digits, 10 ENTER, 11 CLEAR, 12 RESET_ALL, 13 SET, 14 BACK
  localparam int K_ENT = 10, K_CLR = 11, K_RST = 12, K_SET = 13, K_BCK = 14;
  logic [15:0] kmap [0:14] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800,
                               16'h0400, 16'h0200, 16'h8000, 16'h4000, 16'h2000,
                               16'h0001, 16'h1000, 16'h0100, 16'h0002, 16'h0004};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_state(input string tag, input logic [11:0] e_disp, input logic [2:0] e_cnt,
                           input logic e_unl, input logic e_lo, input logic [3:0] e_tries);
    chk({tag, ".disp"}, 32'(disp), 32'(e_disp));
    chk({tag, ".disp_cnt"}, 32'(disp_cnt), 32'(e_cnt));
    chk({tag, ".unlocked"}, 32'(unlocked), 32'(e_unl));
    chk({tag, ".locked_out"}, 32'(locked_out), 32'(e_lo));
    chk({tag, ".tries"}, 32'(tries), 32'(e_tries));
  endtask

  task automatic press_pat(input logic [15:0] pat, input int hold);
    @(negedge clk) onehot = pat;
    repeat (hold) @(negedge clk);
    onehot = 16'h0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input int k);
    press_pat(kmap[k], 5);
  endtask

  // Press a key and count buzzer-high cycles over a window from the press
  task automatic press_count(input int k, input int hold, input int window, output int hi);
    hi = 0;
    @(negedge clk) onehot = kmap[k];
    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      if (c == hold - 1) onehot = 16'h0000;
      if (buzzer) hi++;
    end
  endtask

  // High cycles expected from a tone: starts high, toggles every half
  // period, silent for elapsed counts strictly between mlo and mhi.
  function automatic int tone_high(input int dur, input int half, input int mlo, input int mhi);
    int n = 0;
    for (int e = 0; e < dur; e++)
      if (((e / half) % 2 == 0) && !(e > mlo && e < mhi)) n++;
    return n;
  endfunction

  task automatic do_reset();
    onehot = 16'h0000;
    @(negedge clk) RSTn = 1'b0;
    repeat (3) @(negedge clk);
    RSTn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- reference model (digit-list level) ----------------
  int          m_mode;   // 0 entry, 1 unlocked, 2 set-new, 3 lockout
  int          m_dig[$];
  logic [11:0] m_code;
  int          m_tries;

  function automatic logic [11:0] m_disp();
    logic [11:0] v;
    int n;
    v = 12'hFFF;
    n = m_dig.size();
    for (int i = 0; i < n; i++) v[4*i +: 4] = 4'(m_dig[n-1-i]);
    return v;
  endfunction

  task automatic model_press(input int k);
    if (k == K_RST) begin
      m_mode = 0; m_dig.delete(); m_tries = 0;
    end else if (k > 14) begin
      // invalid pattern: no effect
    end else if (m_mode == 1) begin
      if (k == K_CLR) begin m_mode = 0; m_dig.delete(); end
      else if (k == K_SET) begin m_mode = 2; m_dig.delete(); end
    end else if (m_mode == 0 || m_mode == 2) begin
      if (k <= 9) begin
        if (m_dig.size() < 3) m_dig.push_back(k);
      end else if (k == K_BCK) begin
        if (m_dig.size() > 0) void'(m_dig.pop_back());
      end else if (k == K_CLR) begin
        m_dig.delete();
        if (m_mode == 2) m_mode = 1;
      end else if (k == K_ENT && m_dig.size() == 3) begin
        if (m_mode == 2) begin m_code = m_disp(); m_mode = 1; end
        else if (m_disp() == m_code) begin m_mode = 1; m_tries = 0; end
        else begin
          m_dig.delete();
          m_tries++;
          if (m_tries == 3) begin m_mode = 3; m_tries = 0; end
        end
      end
    end
  endtask

  typedef struct {
    int          key;
    logic [11:0] disp;
    logic [2:0]  cnt;
    logic        unl;
    logic [3:0]  tries;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int k, input logic [11:0] d, input logic [2:0] c,
                     input logic u, input logic [3:0] t);
    vec_t v;
    v.key = k; v.disp = d; v.cnt = c; v.unl = u; v.tries = t;
    vecs.push_back(v);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, c, lockp, k, a, b;
    logic [15:0] pat;

    RSTn   = 1'b0;
    onehot = 16'h0000;
    repeat (3) @(negedge clk);
    chk_state("reset", 12'hFFF, 3'd0, 1'b0, 1'b0, 4'd0);
    chk("reset.lock_remain", 32'(lock_remain), 32'h0);
    chk("reset.buzzer", 32'(buzzer), 32'h0);
    RSTn = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- table-driven sequence ----------------
    add(2, 12'hFF2, 1, 0, 0);     add(4, 12'hF24, 2, 0, 0);
    add(6, 12'h246, 3, 0, 0);     add(7, 12'h246, 3, 0, 0);
    add(K_ENT, 12'h246, 3, 1, 0); add(K_SET, 12'hFFF, 0, 1, 0);
    add(9, 12'hFF9, 1, 1, 0);     add(0, 12'hF90, 2, 1, 0);
    add(K_BCK, 12'hFF9, 1, 1, 0); add(0, 12'hF90, 2, 1, 0);
    add(1, 12'h901, 3, 1, 0);     add(K_ENT, 12'h901, 3, 1, 0);
    add(K_CLR, 12'hFFF, 0, 0, 0); add(K_BCK, 12'hFFF, 0, 0, 0);
    add(K_ENT, 12'hFFF, 0, 0, 0); add(2, 12'hFF2, 1, 0, 0);
    add(4, 12'hF24, 2, 0, 0);     add(6, 12'h246, 3, 0, 0);
    add(K_ENT, 12'hFFF, 0, 0, 1); add(9, 12'hFF9, 1, 0, 1);
    add(0, 12'hF90, 2, 0, 1);     add(1, 12'h901, 3, 0, 1);
    add(K_ENT, 12'h901, 3, 1, 0); add(K_CLR, 12'hFFF, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].key);
      chk_state($sformatf("vec%0d", i), vecs[i].disp, vecs[i].cnt, vecs[i].unl, 1'b0, vecs[i].tries);
    end

    // ---------------- buzzer tones (code is now 901) ----------------
    repeat (700) @(negedge clk);
    press_count(9, 5, 400, hi);
    chk("click.high", 32'(hi), 32'(tone_high(HZ/5, 1, HZ, HZ)));
    chk("click.idle", 32'(buzzer), 32'h0);
    press(0); press(1);
    repeat (300) @(negedge clk);
    press_count(K_ENT, 5, 800, hi);
    chk("success.high", 32'(hi), 32'(tone_high(3*HZ/5, 1, HZ, HZ)));
    chk("success.unlocked", 32'(unlocked), 32'h1);
    chk("success.idle", 32'(buzzer), 32'h0);
    press(K_CLR);

    // ---------------- held key, overflow, back ----------------
    repeat (300) @(negedge clk);
    press_count(5, 50, 400, hi);
    chk("held.click", 32'(hi), 32'(tone_high(HZ/5, 1, HZ, HZ)));
    chk_state("held", 12'hFF5, 3'd1, 1'b0, 1'b0, 4'd0);
    press(K_CLR); press(1); press(2); press(3);
    repeat (300) @(negedge clk);
    press_count(4, 5, 300, hi);
    chk("overflow.silent", 32'(hi), 32'h0);
    chk_state("overflow", 12'h123, 3'd3, 1'b0, 1'b0, 4'd0);
    press(K_BCK);
    chk_state("back", 12'hF12, 3'd2, 1'b0, 1'b0, 4'd0);
    press(K_CLR);

    // ---------------- lockout with countdown ----------------
    press(1); press(1); press(1); press(K_ENT);
    chk_state("try1", 12'hFFF, 3'd0, 1'b0, 1'b0, 4'd1);
    press(1); press(1); press(1);
    repeat (300) @(negedge clk);
    press_count(K_ENT, 5, 400, hi);
    chk("fail.high", 32'(hi), 32'(tone_high(3*HZ/10, 2, HZ/10, HZ/5)));
    chk("try2.tries", 32'(tries), 32'h2);
    press(1); press(1); press(1);
    @(negedge clk) onehot = kmap[K_ENT];
    c = 0;
    while (!locked_out && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 5) onehot = 16'h0000;
    end
    onehot = 16'h0000;
    chk("lock.entered", 32'(locked_out), 32'h1);
    chk("lock.remain3", 32'(lock_remain), 32'h03);
    chk("lock.tries0", 32'(tries), 32'h0);
    for (int s = 3; s >= 1; s--) begin
      c = 0;
      while (lock_remain == 8'(s) && c < 1100) begin
        @(negedge clk);
        c++;
        if (s == 3 && c == 100) onehot = kmap[7];
        if (s == 3 && c == 105) onehot = 16'h0000;
      end
      chk($sformatf("lock.period%0d", s), 32'(c), 32'd1000);
      chk($sformatf("lock.remain%0d", s - 1), 32'(lock_remain), 32'(s - 1));
      chk($sformatf("lock.disp%0d", s), 32'(disp), 32'hFFF);
    end
    chk("lock.exit", 32'(locked_out), 32'h0);
    chk("lock.exit_unl", 32'(unlocked), 32'h0);

    // ---------------- RESET_ALL during lockout ----------------
    for (int t = 0; t < 3; t++) begin press(1); press(1); press(1); press(K_ENT); end
    chk("rall.locked", 32'(locked_out), 32'h1);
    press(K_RST);
    chk("rall.locked_out", 32'(locked_out), 32'h0);
    chk("rall.remain", 32'(lock_remain), 32'h0);
    chk("rall.tries", 32'(tries), 32'h0);
    chk("rall.unl", 32'(unlocked), 32'h0);

    // ---------------- async reset mid-lockout, mid-tone ----------------
    for (int t = 0; t < 3; t++) begin press(1); press(1); press(1); press(K_ENT); end
    chk("arst.pre_locked", 32'(locked_out), 32'h1);
    @(negedge clk);
    #2 RSTn = 1'b0;
    #1;
    chk_state("arst", 12'hFFF, 3'd0, 1'b0, 1'b0, 4'd0);
    chk("arst.remain", 32'(lock_remain), 32'h0);
    chk("arst.buzzer", 32'(buzzer), 32'h0);
    @(negedge clk) RSTn = 1'b1;
    repeat (2) @(negedge clk);
    press(9); press(0); press(1); press(K_ENT);
    chk_state("arst.901", 12'hFFF, 3'd0, 1'b0, 1'b0, 4'd1);
    press(2); press(4); press(6); press(K_ENT);
    chk_state("arst.246", 12'h246, 3'd3, 1'b1, 1'b0, 4'd0);

    // ---------------- randomized vs. reference model ----------------
    do_reset();
    m_mode = 0; m_dig.delete(); m_code = 12'h246; m_tries = 0;
    lockp = 0;
    for (int n = 0; n < 300; n++) begin
      if (m_mode == 3) begin
        lockp++;
        k = ($urandom_range(0, 1) == 0 || lockp > 4) ? K_RST : $urandom_range(0, 14);
      end else begin
        lockp = 0;
        a = $urandom_range(0, 99);
        if (a < 45)      k = (a % 3 == 0) ? 2 : (a % 3 == 1) ? 4 : 6;
        else if (a < 60) k = $urandom_range(0, 9);
        else if (a < 95) k = $urandom_range(10, 14);
        else             k = 15;
      end
      if (k == 15) begin
        a = $urandom_range(0, 14);
        b = (a + 1 + $urandom_range(0, 13)) % 15;
        pat = kmap[a] | kmap[b];
      end else begin
        pat = kmap[k];
      end
      press_pat(pat, $urandom_range(1, 6));
      model_press(k);
      chk_state($sformatf("rnd%0d", n), m_disp(), 3'(m_dig.size()),
                (m_mode == 1 || m_mode == 2), (m_mode == 3), 4'(m_tries));
      chk($sformatf("rnd%0d.remain", n), 32'(lock_remain), (m_mode == 3) ? 32'h03 : 32'h00);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
